// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: bundle of the ID-side inputs and EX-side outputs of the
// ID/EX pipeline register.
//   master : drives the decoded ID fields and flush, observes the EX fields,
//            stall and stallCount (decode stage / testbench side)
//   slave  : the ID/EX register itself
interface id_ex_stage_if #(
  parameter int DW = 64
);
  // ID side
  logic          idValid;
  logic [4:0]    idRn;
  logic [4:0]    idRm;
  logic [4:0]    idRd;
  logic          idUsesRm;
  logic [DW-1:0] idDa;
  logic [DW-1:0] idDb;
  logic [DW-1:0] idImm;
  logic [1:0]    idWB;
  logic [1:0]    idMEM;
  logic [3:0]    idEX;
  logic          flush;
  // EX side
  logic          exValid;
  logic [4:0]    exRn;
  logic [4:0]    exRm;
  logic [4:0]    exRd;
  logic [DW-1:0] exDa;
  logic [DW-1:0] exDb;
  logic [DW-1:0] exImm;
  logic [1:0]    exWB;
  logic [1:0]    exMEM;
  logic [3:0]    exEX;
  logic          stall;
  logic [15:0]   stallCount;

  modport master (
    output idValid, idRn, idRm, idRd, idUsesRm, idDa, idDb, idImm,
           idWB, idMEM, idEX, flush,
    input  exValid, exRn, exRm, exRd, exDa, exDb, exImm, exWB, exMEM, exEX,
           stall, stallCount
  );

  modport slave (
    input  idValid, idRn, idRm, idRd, idUsesRm, idDa, idDb, idImm,
           idWB, idMEM, idEX, flush,
    output exValid, exRn, exRm, exRd, exDa, exDb, exImm, exWB, exMEM, exEX,
           stall, stallCount
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the 64-bit LEGv8 pipeline with
// load-use hazard detection.
//   clk   : pipeline clock, all state updates on the rising edge
//   reset : asynchronous, active-high
//   bus   : id_ex_stage_if.slave -- decoded ID fields and flush in;
//           registered EX fields, combinational stall and the saturating
//           load-use stall counter out
// A load in EX whose destination is read by the instruction in ID forces a
// one-cycle stall and a bubble; a flush squashes the ID instruction into a
// bubble without stalling.
module id_ex_stage #(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          reset,
  id_ex_stage_if.slave  bus
);

  localparam logic [4:0] XZR = 5'd31;

  logic          ex_valid_reg;
  logic [4:0]    ex_rn_reg;
  logic [4:0]    ex_rm_reg;
  logic [4:0]    ex_rd_reg;
  logic [DW-1:0] ex_da_reg;
  logic [DW-1:0] ex_db_reg;
  logic [DW-1:0] ex_imm_reg;
  logic [1:0]    ex_wb_reg;
  logic [1:0]    ex_mem_reg;
  logic [3:0]    ex_ex_reg;
  logic [15:0]   stall_count_reg;

  logic hazard;
  logic stall;
  logic bubble;
  logic rn_match;
  logic rm_match;

  // XZR is never a real producer or consumer, so it can never cause a hazard.
  assign rn_match = (ex_rd_reg == bus.idRn) && (bus.idRn != XZR);
  assign rm_match = bus.idUsesRm && (ex_rd_reg == bus.idRm) && (bus.idRm != XZR);
  assign hazard   = bus.idValid && ex_valid_reg && ex_mem_reg[0] &&
                    (ex_rd_reg != XZR) && (rn_match || rm_match);
  // A wrong-path instruction is discarded, so it is never held.
  assign stall    = hazard && !bus.flush;
  assign bubble   = bus.flush || hazard;

  // Control and indices: a bubble loads XZR indices so forwarding never
  // matches it, and zero control so it has no side effects.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_reg <= 1'b0;
      ex_rn_reg    <= XZR;
      ex_rm_reg    <= XZR;
      ex_rd_reg    <= XZR;
      ex_wb_reg    <= 2'b00;
      ex_mem_reg   <= 2'b00;
      ex_ex_reg    <= 4'b0000;
    end else if (bubble) begin
      ex_valid_reg <= 1'b0;
      ex_rn_reg    <= XZR;
      ex_rm_reg    <= XZR;
      ex_rd_reg    <= XZR;
      ex_wb_reg    <= 2'b00;
      ex_mem_reg   <= 2'b00;
      ex_ex_reg    <= 4'b0000;
    end else begin
      ex_valid_reg <= bus.idValid;
      ex_rn_reg    <= bus.idRn;
      ex_rm_reg    <= bus.idRm;
      ex_rd_reg    <= bus.idRd;
      ex_wb_reg    <= bus.idWB;
      ex_mem_reg   <= bus.idMEM;
      ex_ex_reg    <= bus.idEX;
    end
  end

  // Operand data is meaningless in a bubble, so it simply holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_da_reg  <= '0;
      ex_db_reg  <= '0;
      ex_imm_reg <= '0;
    end else if (!bubble) begin
      ex_da_reg  <= bus.idDa;
      ex_db_reg  <= bus.idDb;
      ex_imm_reg <= bus.idImm;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_reg <= 16'h0000;
    end else if (stall && (stall_count_reg != 16'hFFFF)) begin
      stall_count_reg <= stall_count_reg + 16'h0001;
    end
  end

  assign bus.exValid    = ex_valid_reg;
  assign bus.exRn       = ex_rn_reg;
  assign bus.exRm       = ex_rm_reg;
  assign bus.exRd       = ex_rd_reg;
  assign bus.exDa       = ex_da_reg;
  assign bus.exDb       = ex_db_reg;
  assign bus.exImm      = ex_imm_reg;
  assign bus.exWB       = ex_wb_reg;
  assign bus.exMEM      = ex_mem_reg;
  assign bus.exEX       = ex_ex_reg;
  assign bus.stall      = stall;
  assign bus.stallCount = stall_count_reg;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with load-use hazard detection for the 5-stage 64-bit LEGv8 pipeline. It captures decoded operands, register indices and control bundles at the ID/EX boundary. It presents Rn/Rm/Rd and the WB control to the EX-stage forwarding logic. It stalls the front end and inserts a bubble when an instruction in ID needs the result of a load currently in EX, and it squashes the ID instruction on a taken-branch flush.

## Interface
- DW, 64, operand/immediate datapath width
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- idValid  in  1  ID holds a real instruction
- idRn, idRm, idRd  in  5 each  decoded register indices (31 = XZR)
- idUsesRm  in  1  instruction reads idRm (0 for I/D-type ALU-immediate and loads)
- idDa, idDb, idImm  in  DW each  register-file read data and extended immediate
- idWB  in  2  [1]=RegWrite, [0]=MemToReg
- idMEM  in  2  [1]=MemWrite, [0]=MemRead
- idEX  in  4  ALUSrc + ALUOp bundle, opaque to this block
- flush  in  1  taken branch resolved; the ID instruction is wrong-path
- exValid  out  1  EX holds a real instruction
- exRn, exRm, exRd  out  5 each  registered indices to forwarding/EX
- exDa, exDb, exImm  out  DW each  registered data
- exWB, exMEM  out  2 each; exEX  out  4  registered control
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- stallCount  out  16  saturating count of load-use stall cycles

## Operation
- hazard = idValid & exValid & exMEM[0] & (exRd != 31) & ((exRd == idRn & idRn != 31) | (idUsesRm & exRd == idRm & idRm != 31)).
- stall = hazard & ~flush. A wrong-path instruction is never stalled.
- Each rising edge resolves in priority order:
  - bubble = flush | hazard: load exValid=0, exWB=0, exMEM=0, exEX=0, exRn=exRm=exRd=31. Data registers are don't-care; hold their previous value.
  - otherwise: capture all id* fields, exValid=idValid.
- If idValid=0 without flush or hazard, the fields are still captured. Control is loaded as given, and upstream guarantees zero control on invalid.
- Indices load 31 on every bubble. The forwarding unit therefore sees XZR and never matches a bubble.
- stallCount increments by 1 on each edge where stall=1. It saturates at 16'hFFFF and does not wrap.
- The stall never lasts more than one cycle per load. After the bubble, exMEM[0]=0 and the hazard clears. The held instruction is then captured, and the load result reaches it through MEM/WB forwarding.
- Back-to-back loads are handled. Load A is followed by load B, which depends on A: B stalls one cycle. An instruction C that depends on B stalls one cycle after B enters EX.

## Timing
- On reset assertion, immediately and independent of clk:
  - exValid=0, exWB=0, exMEM=0, exEX=0
  - exRn=exRm=exRd=31
  - exDa=exDb=exImm=0
  - stallCount=0
- On reset, stall=0 follows combinationally, because exValid=0.
- Reset mid-stall: the bubble is abandoned, state is the reset state, and stall drops in the same cycle.
- Latency: id* to ex* is exactly one edge. stall and hazard are same-cycle combinational from current ex* and id* values.
- Stall/bubble handshake: in the cycle stall=1, upstream holds IF/ID and the PC. On the next edge this block loads a bubble. In the following cycle stall=0 and the same ID instruction is captured on the next edge. The instruction is never lost or duplicated.
- flush with hazard in the same cycle: the bubble is loaded, stall=0, and stallCount does not increment.

## Test plan
- Reset mid-run with exRd=5 loaded -> all ex* outputs take their reset values asynchronously (exRd=31, exWB=0), and stall=0 before the next edge.
- Sequence "LDUR X5,[X1]" then "ADD X6,X5,X2" (idRn=5) -> stall=1 for exactly one cycle, and one bubble is inserted (exValid=0, exRd=31). ADD then appears in EX with exRn=5, and stallCount=1.
- LDUR X5 followed by "ADDI X6,X7,#4" with idUsesRm=0 and idRm=5 -> no stall; ADDI enters EX on the next edge.
- LDUR X31 (exRd=31) followed by ADD using Rn=31 -> no stall.
- LDUR X5 followed by dependent ADD, with flush=1 in the same cycle -> stall=0, bubble loaded, stallCount unchanged.
- Force 65,540 load-use pairs -> stallCount saturates at 16'hFFFF and holds.
